p19_vga_timing: RTL
===================

P19_VGA_TIMING -- requirements
Module: p19_vga_timing

Interface
REQ-001 SHALL have parameter H_VISIBLE, default 640, active pixels per line.
REQ-002 SHALL have parameters H_FRONT, H_SYNC, H_BACK, defaults 16, 96, 48, horizontal porch and sync widths in pixels; H_TOTAL is the sum of the four horizontal parameters.
REQ-003 SHALL have parameters V_VISIBLE, V_FRONT, V_SYNC, V_BACK, defaults 480, 10, 2, 33, widths in lines; V_TOTAL is the sum of the four vertical parameters.
REQ-004 SHALL have parameters HS_POL and VS_POL, default 0 each; value 0 means the sync is active-low.
REQ-005 SHALL have parameter SCALE, default 0, range 0..3; output coordinates are divided by 2^SCALE.
REQ-006 SHALL have parameter FCW, default 8, frame counter width.
REQ-007 clk  in  1  pixel clock; single clock domain.
REQ-008 rst_n  in  1  synchronous, active-low reset.
REQ-009 ce  in  1  pixel clock enable; all state advances only on clk edges with ce=1.
REQ-010 hs / vs  out  1 each  horizontal / vertical sync, polarity per HS_POL / VS_POL.
REQ-011 de  out  1  display enable, high for visible pixels only.
REQ-012 x  out  clog2(H_VISIBLE>>SCALE)  scaled column; y  out  clog2(V_VISIBLE>>SCALE)  scaled row.
REQ-013 line_start / frame_start  out  1 each  one-enabled-cycle strobes.
REQ-014 frame_cnt  out  FCW  free-running frame count.

Function
REQ-015 Internal h_cnt SHALL count 0..H_TOTAL-1 and wrap to 0; v_cnt SHALL count 0..V_TOTAL-1, increment when h_cnt wraps, and wrap to 0 when both counters are at terminal count.
REQ-016 All outputs SHALL be registered, loaded from the current h_cnt/v_cnt on each enabled edge (one enabled cycle latency), and mutually aligned.
REQ-017 de SHALL be 1 iff h_cnt < H_VISIBLE and v_cnt < V_VISIBLE.
REQ-018 hs SHALL be active iff H_VISIBLE+H_FRONT <= h_cnt < H_VISIBLE+H_FRONT+H_SYNC.
REQ-019 vs SHALL be active for whole lines iff V_VISIBLE+V_FRONT <= v_cnt < V_VISIBLE+V_FRONT+V_SYNC.
REQ-020 x SHALL be h_cnt>>SCALE and y SHALL be v_cnt>>SCALE while de=1; both SHALL hold their last value while de=0.
REQ-021 line_start SHALL be 1 iff h_cnt==0 and v_cnt<V_VISIBLE; frame_start SHALL be 1 iff h_cnt==0 and v_cnt==0.
REQ-022 frame_cnt SHALL increment, modulo 2^FCW, on the same edge at which frame_start is loaded to 1.
REQ-023 With ce=0, all counters and outputs SHALL hold, and strobes SHALL stay at their held value; ce=0 never lengthens a strobe beyond one enabled cycle in pixel time.
REQ-024 Out-of-range parameters (any width 0, SCALE>3, H_VISIBLE or V_VISIBLE not divisible by 2^SCALE) SHALL cause an elaboration error.

Reset
REQ-025 While rst_n=0 at a clk edge, regardless of ce: h_cnt=0, v_cnt=0, de=0, x=0, y=0, line_start=0, frame_start=0, frame_cnt=0, hs=!HS_POL and vs=!VS_POL (inactive).
REQ-026 On the first enabled edge after rst_n rises, the outputs SHALL show de=1, x=0, y=0, line_start=1 and frame_start=1, with frame_cnt unchanged at 0 on that edge.
REQ-027 Reset asserted mid-frame SHALL take effect on the next clk edge with no partial line completion.

Structure
REQ-028 Package p19_vga_pkg SHALL hold the default 640x480 timing constants and a width-calculation function.
REQ-029 One sub-module, p19_wrap_counter, SHALL provide a parametrised modulo-N counter with enable, synchronous active-low reset and terminal-count output; it is instantiated twice (h and v).

Verification
REQ-030 Defaults, ce=1, two full frames: de high 640x480 per frame; hs low for cycles 656..751 of each 800-cycle line; vs low for lines 490..491; frame period 420000 cycles.
REQ-031 Reset release: first enabled edge shows de=1, x=0, y=0, frame_start=1; frame_start recurs exactly every 420000 cycles; frame_cnt wraps 255->0 after 256 frames.
REQ-032 ce toggled 1,0 every cycle: sync/de waveforms identical in enabled-cycle time to REQ-030, and no output changes on any ce=0 edge.
REQ-033 SCALE=1: x steps 0,0,1,1,...,319,319 per line and y repeats each value on two consecutive lines up to 239.
REQ-034 HS_POL=1, VS_POL=1, small timing (8,2,2,2 / 4,1,1,1): hs high for cycles 10..11, vs high on line 5, H_TOTAL=14, V_TOTAL=7.
REQ-035 rst_n pulsed low for 1 cycle at h_cnt=400, v_cnt=300: outputs at reset values on the next edge; the next enabled edge shows de=1 at (0,0).

Source files
------------

// File: rtl/p19_vga_pkg.sv
// Shared timing constants (640x480 @ 25.175 MHz) and counter width helper.
package p19_vga_pkg;

  localparam int DEF_H_VISIBLE = 640;
  localparam int DEF_H_FRONT   = 16;
  localparam int DEF_H_SYNC    = 96;
  localparam int DEF_H_BACK    = 48;
  localparam int DEF_V_VISIBLE = 480;
  localparam int DEF_V_FRONT   = 10;
  localparam int DEF_V_SYNC    = 2;
  localparam int DEF_V_BACK    = 33;

  // Bits needed to hold 0..n-1, never less than one.
  function automatic int cnt_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/p19_wrap_counter.sv
// Modulo-N up-counter with enable, synchronous active-low reset and terminal count.
module p19_wrap_counter #(
  parameter int N = 2,
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  output logic [W-1:0] cnt,
  output logic         tc
);

  assign tc = (cnt == W'(N - 1));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= tc ? '0 : cnt + 1'b1;
    end
  end

endmodule

// File: rtl/p19_vga_timing.sv
// VGA raster timing generator: h/v position counters plus registered sync, de,
// scaled coordinates, line/frame strobes and a free-running frame counter.
module p19_vga_timing
  import p19_vga_pkg::*;
#(
  parameter int H_VISIBLE = DEF_H_VISIBLE,
  parameter int H_FRONT   = DEF_H_FRONT,
  parameter int H_SYNC    = DEF_H_SYNC,
  parameter int H_BACK    = DEF_H_BACK,
  parameter int V_VISIBLE = DEF_V_VISIBLE,
  parameter int V_FRONT   = DEF_V_FRONT,
  parameter int V_SYNC    = DEF_V_SYNC,
  parameter int V_BACK    = DEF_V_BACK,
  parameter int HS_POL    = 0,
  parameter int VS_POL    = 0,
  parameter int SCALE     = 0,
  parameter int FCW       = 8,
  localparam int XW = cnt_width(H_VISIBLE >> SCALE),
  localparam int YW = cnt_width(V_VISIBLE >> SCALE)
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           ce,
  output logic           hs,
  output logic           vs,
  output logic           de,
  output logic [XW-1:0]  x,
  output logic [YW-1:0]  y,
  output logic           line_start,
  output logic           frame_start,
  output logic [FCW-1:0] frame_cnt
);

  localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
  localparam int HW = cnt_width(H_TOTAL);
  localparam int VW = cnt_width(V_TOTAL);

  localparam logic [HW-1:0] H_VIS_END  = HW'(H_VISIBLE);
  localparam logic [HW-1:0] H_SYNC_BEG = HW'(H_VISIBLE + H_FRONT);
  localparam logic [HW-1:0] H_SYNC_END = HW'(H_VISIBLE + H_FRONT + H_SYNC);
  localparam logic [VW-1:0] V_VIS_END  = VW'(V_VISIBLE);
  localparam logic [VW-1:0] V_SYNC_BEG = VW'(V_VISIBLE + V_FRONT);
  localparam logic [VW-1:0] V_SYNC_END = VW'(V_VISIBLE + V_FRONT + V_SYNC);
  localparam logic HS_ACT = (HS_POL != 0);
  localparam logic VS_ACT = (VS_POL != 0);

  if (H_VISIBLE < 1 || H_FRONT < 1 || H_SYNC < 1 || H_BACK < 1 ||
      V_VISIBLE < 1 || V_FRONT < 1 || V_SYNC < 1 || V_BACK < 1 ||
      FCW < 1 || SCALE < 0 || SCALE > 3 ||
      (H_VISIBLE % (1 << SCALE)) != 0 || (V_VISIBLE % (1 << SCALE)) != 0) begin : g_param_err
    $error("p19_vga_timing: illegal timing, SCALE or FCW parameter");
  end

  logic [HW-1:0] h_cnt;
  logic [VW-1:0] v_cnt;
  logic          h_tc;
  logic          v_tc;

  p19_wrap_counter #(.N(H_TOTAL), .W(HW)) u_h_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (ce),
    .cnt   (h_cnt),
    .tc    (h_tc)
  );

  p19_wrap_counter #(.N(V_TOTAL), .W(VW)) u_v_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (ce & h_tc),
    .cnt   (v_cnt),
    .tc    (v_tc)
  );

  logic de_n, hs_n, vs_n, ls_n, fs_n;
  // Set once a full frame has elapsed, so the frame_start right after reset is frame 0.
  logic wrapped;

  assign de_n = (h_cnt < H_VIS_END) && (v_cnt < V_VIS_END);
  assign hs_n = (h_cnt >= H_SYNC_BEG) && (h_cnt < H_SYNC_END);
  assign vs_n = (v_cnt >= V_SYNC_BEG) && (v_cnt < V_SYNC_END);
  assign ls_n = (h_cnt == '0) && (v_cnt < V_VIS_END);
  assign fs_n = (h_cnt == '0) && (v_cnt == '0);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      hs          <= ~HS_ACT;
      vs          <= ~VS_ACT;
      de          <= 1'b0;
      x           <= '0;
      y           <= '0;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
      frame_cnt   <= '0;
      wrapped     <= 1'b0;
    end else if (ce) begin
      hs          <= hs_n ? HS_ACT : ~HS_ACT;
      vs          <= vs_n ? VS_ACT : ~VS_ACT;
      de          <= de_n;
      line_start  <= ls_n;
      frame_start <= fs_n;
      if (de_n) begin
        x <= XW'(h_cnt >> SCALE);
        y <= YW'(v_cnt >> SCALE);
      end
      if (fs_n && wrapped) begin
        frame_cnt <= frame_cnt + 1'b1;
      end
      if (h_tc && v_tc) begin
        wrapped <= 1'b1;
      end
    end
  end

endmodule
